vga_sync_monitor: RTL and testbench
===================================

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_TOTAL, 800, pixels per line.
- H_SYNC, 96, h_sync pulse width in pixels.
- H_ACT_START, 144, first active pixel.
- H_ACT_END, 784, first pixel past the active region.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, v_sync pulse width in lines.
- V_ACT_START, 35, first active line.
- V_ACT_END, 515, first line past the active region.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock.
- rst, in, 1, reset; asynchronous, active-high.
- pix_en, in, 1, pixel strobe; all video inputs are sampled only when it is 1.
- h_sync, in, 1, horizontal sync, active-high.
- v_sync, in, 1, vertical sync, active-high.
- red / green / blue, in, 3 each, pixel colour.
- locked, out, 1, timing lock indicator.
- h_pos / v_pos, out, 10 each, recovered counters.
- active, out, 1, recovered position is inside the active region.
- frame_done, out, 1, one-cycle end-of-frame pulse.
- obj_valid, out, 1, previous frame contained an object pixel.
- obj_x_min / obj_x_max / obj_y_min / obj_y_max, out, 10 each, object bounding box.
- err_count, out, 8, saturating timing-error count.

Function
REQ-003 All state shall advance only on clk edges with pix_en=1; with pix_en=0 all state holds and frame_done=0.
REQ-004 An h-rise is a sample with h_sync=1 when the previous sample had h_sync=0; a v-rise is the same test on v_sync, evaluated only at h-rise samples.
REQ-005 h_pos:
- At an h-rise, h_pos shall load 0.
- Otherwise it shall increment, saturating at 1023.
REQ-006 v_pos:
- At an h-rise with a v-rise, v_pos shall load 0.
- At an h-rise without a v-rise, it shall increment, saturating at 1023.
REQ-007 active shall be 1 iff H_ACT_START<=h_pos<H_ACT_END and V_ACT_START<=v_pos<V_ACT_END, registered with h_pos/v_pos.
REQ-008 Errors:
- Line error: h_pos != H_TOTAL-1 on the sample before an h-rise.
- Frame error: v_pos != V_TOTAL-1 at a v-rise.
- H-width error: the first h_sync=0 sample after an h-rise occurs at h_pos != H_SYNC.
- V-width error: the first v_sync=0 h-rise occurs at v_pos != V_SYNC.
REQ-009 The FSM shall have states SEARCH, TRACK and LOCKED; locked=1 only in LOCKED.
REQ-010 SEARCH shall go to TRACK at the first v-rise.
REQ-011 TRACK shall go to LOCKED after 2 consecutive error-free frames, each closed by a v-rise.
REQ-012 Any line or frame error in TRACK or LOCKED shall return the FSM to SEARCH; width errors shall be counted only.
REQ-013 An object pixel is a sample in LOCKED with active=1 and red=green=blue=3'b111.
REQ-014 Object coordinates shall be x=h_pos-H_ACT_START and y=v_pos-V_ACT_START.
REQ-015 During each frame, running minimum and maximum x and y shall be accumulated over object pixels.
REQ-016 At a v-rise in LOCKED:
- frame_done=1 for exactly one clk.
- The obj_* outputs shall be updated on the same edge.
- obj_valid=1 with the accumulated box if any object pixel was seen.
- Otherwise obj_valid=0 and all four coordinates are 0.
- The accumulators then clear.
REQ-017 A v-rise that causes LOCKED->SEARCH shall not pulse frame_done, and obj_* shall hold their values.
REQ-018 A single-pixel object shall give min=max on both axes.
REQ-019 An object at pixel (0,0) shall give obj_valid=1 with all coordinates 0.

Reset
REQ-020 rst=1 shall immediately force:
- State SEARCH.
- All outputs to 0.
- All accumulators cleared and the previous-sync registers set to 0.
REQ-021 Reset asserted mid-frame shall discard the partial frame, with no frame_done pulse.

Configuration
REQ-022 With VGA_MON_ERR_CNT_EN defined:
- err_count shall increment by 1 per detected error of any kind, saturating at 255.
- err_count is cleared only by rst.
- Two errors on the same sample shall count as 2, limited by saturation.
REQ-023 With VGA_MON_ERR_CNT_EN undefined, err_count shall be constant 0 and no counter logic shall be built; all other behaviour is unchanged.

Verification
REQ-024 Drive 3 frames of nominal 800x525 timing with no object -> locked=1 after the 3rd v-rise, obj_valid=0, err_count=0.
REQ-025 Once locked, draw a white 20x20 square at h=244..263, v=135..154 -> frame_done pulse; obj_x_min=100, x_max=119, y_min=100, y_max=119, obj_valid=1.
REQ-026 Once locked, shorten one line to 799 pixels -> next cycle FSM=SEARCH, locked=0, err_count=1 (macro on) or 0 (macro off).
REQ-027 Once locked, widen one h_sync pulse to 97 -> locked stays 1, err_count increments by 1.
REQ-028 Toggle pix_en at 1/4 duty with nominal video -> results identical to the pix_en=1 case.
REQ-029 Assert rst mid-frame while locked, then release -> all outputs 0, no frame_done; relock after 3 v-rises.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// VGA timing monitor: recovers h/v position from sync edges, locks onto the expected
// raster and reports a per-frame bounding box of white pixels. VGA_MON_ERR_CNT_EN adds an error counter.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [2:0] blue,
    output logic       locked,
    output logic [9:0] h_pos,
    output logic [9:0] v_pos,
    output logic       active,
    output logic       frame_done,
    output logic       obj_valid,
    output logic [9:0] obj_x_min,
    output logic [9:0] obj_x_max,
    output logic [9:0] obj_y_min,
    output logic [9:0] obj_y_max,
    output logic [7:0] err_count
);

    // state     | meaning
    // SEARCH    | waiting for the first vertical sync edge
    // TRACK     | counting error-free frames before declaring lock
    // LOCKED    | timing verified, object box reported each frame
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_AS   = 10'(H_ACT_START);
    localparam logic [9:0] H_AE   = 10'(H_ACT_END);
    localparam logic [9:0] V_AS   = 10'(V_ACT_START);
    localparam logic [9:0] V_AE   = 10'(V_ACT_END);

    logic [1:0] state;
    logic       good_cnt;
    logic       prev_h;
    logic       prev_v;
    logic       h_rise;
    logic       v_rise;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       act_nxt;
    logic       tracking;
    logic       line_err;
    logic       frame_err;
    logic       obj_px;
    logic [9:0] obj_x;
    logic [9:0] obj_y;
    logic       frame_close;
    logic       acc_seen;
    logic [9:0] acc_x_min;
    logic [9:0] acc_x_max;
    logic [9:0] acc_y_min;
    logic [9:0] acc_y_max;

    // Position and object tests use the values this sample will register.
    always_comb begin
        h_rise      = h_sync & ~prev_h;
        v_rise      = h_rise & v_sync & ~prev_v;
        h_nxt       = h_rise ? 10'd0 : ((h_pos == 10'h3ff) ? h_pos : h_pos + 10'd1);
        v_nxt       = v_rise ? 10'd0 :
                      (h_rise ? ((v_pos == 10'h3ff) ? v_pos : v_pos + 10'd1) : v_pos);
        act_nxt     = (h_nxt >= H_AS) && (h_nxt < H_AE) && (v_nxt >= V_AS) && (v_nxt < V_AE);
        tracking    = (state != ST_SEARCH);
        line_err    = tracking & h_rise & (h_pos != H_LAST);
        frame_err   = tracking & v_rise & (v_pos != V_LAST);
        obj_px      = (state == ST_LOCKED) & act_nxt & (&red) & (&green) & (&blue);
        obj_x       = h_nxt - H_AS;
        obj_y       = v_nxt - V_AS;
        frame_close = (state == ST_LOCKED) & v_rise & ~line_err & ~frame_err;
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_SEARCH;
            good_cnt <= 1'b0;
        end else if (pix_en) begin
            case (state)
                ST_SEARCH: begin
                    if (v_rise) begin
                        state    <= ST_TRACK;
                        good_cnt <= 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (line_err || frame_err) begin
                        state <= ST_SEARCH;
                    end else if (v_rise) begin
                        if (good_cnt) begin
                            state <= ST_LOCKED;
                        end
                        good_cnt <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (line_err || frame_err) begin
                        state <= ST_SEARCH;
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_h <= 1'b0;
            prev_v <= 1'b0;
            h_pos  <= 10'd0;
            v_pos  <= 10'd0;
            active <= 1'b0;
        end else if (pix_en) begin
            prev_h <= h_sync;
            prev_v <= v_sync;
            h_pos  <= h_nxt;
            v_pos  <= v_nxt;
            active <= act_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_seen  <= 1'b0;
            acc_x_min <= 10'd0;
            acc_x_max <= 10'd0;
            acc_y_min <= 10'd0;
            acc_y_max <= 10'd0;
        end else if (pix_en) begin
            if (v_rise || (state != ST_LOCKED)) begin
                acc_seen  <= 1'b0;
                acc_x_min <= 10'd0;
                acc_x_max <= 10'd0;
                acc_y_min <= 10'd0;
                acc_y_max <= 10'd0;
            end else if (obj_px) begin
                acc_seen <= 1'b1;
                if (!acc_seen || (obj_x < acc_x_min)) acc_x_min <= obj_x;
                if (!acc_seen || (obj_x > acc_x_max)) acc_x_max <= obj_x;
                if (!acc_seen || (obj_y < acc_y_min)) acc_y_min <= obj_y;
                if (!acc_seen || (obj_y > acc_y_max)) acc_y_max <= obj_y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            obj_valid  <= 1'b0;
            obj_x_min  <= 10'd0;
            obj_x_max  <= 10'd0;
            obj_y_min  <= 10'd0;
            obj_y_max  <= 10'd0;
        end else begin
            frame_done <= 1'b0;
            if (pix_en && frame_close) begin
                frame_done <= 1'b1;
                obj_valid  <= acc_seen;
                obj_x_min  <= acc_seen ? acc_x_min : 10'd0;
                obj_x_max  <= acc_seen ? acc_x_max : 10'd0;
                obj_y_min  <= acc_seen ? acc_y_min : 10'd0;
                obj_y_max  <= acc_seen ? acc_y_max : 10'd0;
            end
        end
    end

`ifdef VGA_MON_ERR_CNT_EN
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);

    logic       hw_arm;
    logic       vw_arm;
    logic       h_width_err;
    logic       v_width_err;
    logic [2:0] err_inc;
    logic [8:0] err_sum;

    // Width checks fire once per pulse, on the first sample after the sync edge that sees it low.
    always_comb begin
        h_width_err = tracking & hw_arm & ~h_sync & (h_nxt != H_SYNC_W);
        v_width_err = tracking & vw_arm & h_rise & ~v_sync & (v_nxt != V_SYNC_W);
        err_inc     = {2'b00, line_err} + {2'b00, frame_err} +
                      {2'b00, h_width_err} + {2'b00, v_width_err};
        err_sum     = {1'b0, err_count} + {6'd0, err_inc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hw_arm    <= 1'b0;
            vw_arm    <= 1'b0;
            err_count <= 8'd0;
        end else if (pix_en) begin
            if (h_rise) begin
                hw_arm <= 1'b1;
            end else if (!h_sync) begin
                hw_arm <= 1'b0;
            end
            if (v_rise) begin
                vw_arm <= 1'b1;
            end else if (h_rise && !v_sync) begin
                vw_arm <= 1'b0;
            end
            err_count <= err_sum[8] ? 8'hff : err_sum[7:0];
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a reduced 40x30 raster; frame results are
// queued by the stimulus and checked by a monitor whenever frame_done pulses.
module tb_vga_sync_monitor;

    localparam int HT = 40;
    localparam int HS = 4;
    localparam int HA = 8;
    localparam int HE = 36;
    localparam int VT = 30;
    localparam int VS = 2;
    localparam int VA = 5;
    localparam int VE = 28;
`ifdef VGA_MON_ERR_CNT_EN
    localparam int ERR_STEP = 1;
`else
    localparam int ERR_STEP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       h_sync;
    logic       v_sync;
    logic [2:0] red;
    logic [2:0] green;
    logic [2:0] blue;
    logic       locked;
    logic [9:0] h_pos;
    logic [9:0] v_pos;
    logic       active;
    logic       frame_done;
    logic       obj_valid;
    logic [9:0] obj_x_min;
    logic [9:0] obj_x_max;
    logic [9:0] obj_y_min;
    logic [9:0] obj_y_max;
    logic [7:0] err_count;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA), .H_ACT_END(HE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA), .V_ACT_END(VE)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue), .locked(locked), .h_pos(h_pos),
        .v_pos(v_pos), .active(active), .frame_done(frame_done), .obj_valid(obj_valid),
        .obj_x_min(obj_x_min), .obj_x_max(obj_x_max), .obj_y_min(obj_y_min),
        .obj_y_max(obj_y_max), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [9:0] x0;
        logic [9:0] x1;
        logic [9:0] y0;
        logic [9:0] y1;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   exp_err  = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic v, input int x0, input int x1, input int y0, input int y1);
        res_t e;
        e.v  = v;
        e.x0 = 10'(x0);
        e.x1 = 10'(x1);
        e.y0 = 10'(y0);
        e.y1 = 10'(y1);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done actual=1 required=0 at t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("obj_valid", int'(obj_valid), int'(mon_e.v));
                check("obj_x_min", int'(obj_x_min), int'(mon_e.x0));
                check("obj_x_max", int'(obj_x_max), int'(mon_e.x1));
                check("obj_y_min", int'(obj_y_min), int'(mon_e.y0));
                check("obj_y_max", int'(obj_y_max), int'(mon_e.y1));
            end
        end
    end

    // One sample: gap idle clocks with pix_en low, then one strobed clock.
    task automatic px(input logic h, input logic v, input logic [8:0] rgb, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            pix_en = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        pix_en = 1'b1;
        h_sync = h;
        v_sync = v;
        red    = rgb[8:6];
        green  = rgb[5:3];
        blue   = rgb[2:0];
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic drive_frame(input int box, input int bx0, input int bx1, input int by0,
                               input int by1, input int short_ln, input int wide_ln,
                               input int gap, input int nlines);
        int len;
        int hw;
        logic white;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == short_ln) ? HT - 1 : HT;
            hw  = (ln == wide_ln) ? HS + 1 : HS;
            for (int k = 0; k < len; k++) begin
                white = (box != 0) && (k >= bx0) && (k <= bx1) && (ln >= by0) && (ln <= by1);
                px(k < hw, ln < VS, white ? 9'o777 : 9'o776, gap);
                if (short_ln >= 0 && ln == short_ln + 1 && k == 0) begin
                    check("short_line_unlock", int'(locked), 0);
                    check("short_line_err_count", int'(err_count), exp_err);
                end
                if (wide_ln >= 0 && ln == wide_ln + 1 && k == 0) begin
                    check("wide_hsync_locked", int'(locked), 1);
                    check("wide_hsync_err_count", int'(err_count), exp_err);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; pix_en = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
        red = 3'd0; green = 3'd0; blue = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", int'(locked), 0);
        check("rst_h_pos", int'(h_pos), 0);
        check("rst_v_pos", int'(v_pos), 0);
        check("rst_active", int'(active), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_obj_valid", int'(obj_valid), 0);
        check("rst_err_count", int'(err_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Acquire lock on nominal video.
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        check("lock_after_vrise1", int'(locked), 0);
        check("vpos_end_frame", int'(v_pos), VT - 1);
        check("hpos_end_line", int'(h_pos), HT - 1);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        check("lock_after_vrise2", int'(locked), 0);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        check("lock_after_vrise3", int'(locked), 1);
        check("nominal_err_count", int'(err_count), 0);
        check("nominal_obj_valid", int'(obj_valid), 0);

        // Square at h=12..15, v=9..12 -> box 4..7 on both axes.
        push_exp(1'b0, 0, 0, 0, 0);
        drive_frame(1, 12, 15, 9, 12, -1, -1, 0, VT);
        push_exp(1'b1, 4, 7, 4, 7);
        drive_frame(1, HA, HA, VA, VA, -1, -1, 0, VT);

        // First active pixel only, then a short line breaks lock.
        push_exp(1'b1, 0, 0, 0, 0);
        exp_err += ERR_STEP;
        drive_frame(0, 0, 0, 0, 0, 10, -1, 0, VT);
        check("after_short_frame_locked", int'(locked), 0);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        check("relock_track", int'(locked), 0);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        check("relock_done", int'(locked), 1);

        // Wide h_sync pulse: counted but lock is kept.
        push_exp(1'b0, 0, 0, 0, 0);
        exp_err += ERR_STEP;
        drive_frame(1, 12, 15, 9, 12, -1, 3, 0, VT);
        push_exp(1'b1, 4, 7, 4, 7);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);

        // Quarter-duty pixel strobe.
        push_exp(1'b0, 0, 0, 0, 0);
        drive_frame(1, 12, 15, 9, 12, -1, -1, 3, VT);
        push_exp(1'b1, 4, 7, 4, 7);
        drive_frame(1, 12, 15, 9, 12, -1, -1, 3, VT);
        check("duty_locked", int'(locked), 1);
        check("duty_err_count", int'(err_count), exp_err);

        // Reset mid-frame while locked.
        push_exp(1'b1, 4, 7, 4, 7);
        drive_frame(1, 12, 15, 9, 12, -1, -1, 0, 15);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_locked", int'(locked), 0);
        check("midrst_h_pos", int'(h_pos), 0);
        check("midrst_v_pos", int'(v_pos), 0);
        check("midrst_active", int'(active), 0);
        check("midrst_obj_valid", int'(obj_valid), 0);
        check("midrst_obj_x_max", int'(obj_x_max), 0);
        check("midrst_obj_y_max", int'(obj_y_max), 0);
        check("midrst_err_count", int'(err_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_err = 0;
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        check("post_rst_vrise1", int'(locked), 0);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        check("post_rst_vrise2", int'(locked), 0);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, VT);
        check("post_rst_vrise3", int'(locked), 1);
        check("post_rst_err_count", int'(err_count), 0);
        push_exp(1'b0, 0, 0, 0, 0);
        drive_frame(0, 0, 0, 0, 0, -1, -1, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("pending_frame_results", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
